// File: rtl/tick_rate_gen.sv
// Purpose: divides CLOCK_50 into a one-cycle TICK strobe at a switch-selected rate, with debounced pause/step keys.
// Latency: TICK every BASE_PERIOD>>RATE_Q cycles; key actions land DEBOUNCE_CYCLES+3..+4 cycles after a clean key fall.
// Backpressure: none; TICK is a free strobe and consumers must sample it on the cycle it is high.

module tick_key_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int DB_W = $clog2(CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(CYCLES - 1);

  logic            key_meta;
  logic            key_sync;
  logic            stable;
  logic [DB_W-1:0] db_cnt;

  // Two-flop synchroniser; reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Accept a new level only after it has differed from the stable state for CYCLES cycles; pulse on stable falls only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= key_sync;
        db_cnt <= '0;
        press  <= stable;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

module tick_rate_gen #(
  parameter int BASE_PERIOD     = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 26
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] SW_RATE,
  input  logic       KEY_PAUSE_N,
  input  logic       KEY_STEP_N,
  output logic       TICK,
  output logic       PAUSED,
  output logic [1:0] RATE_Q
);

  logic [1:0]       sw_meta;
  logic [1:0]       sw_sync;
  logic             pause_press;
  logic             step_press;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_last;

  // Rate switches are asynchronous; resynchronise before they can be loaded into RATE_Q.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta <= 2'b00;
      sw_sync <= 2'b00;
    end else begin
      sw_meta <= SW_RATE;
      sw_sync <= sw_meta;
    end
  end

  tick_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY_PAUSE_N),
    .press (pause_press)
  );

  tick_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY_STEP_N),
    .press (step_press)
  );

  // Terminal count for the rate currently in effect (period minus one).
  always_comb begin
    period_last = CNT_W'(BASE_PERIOD >> RATE_Q) - 1'b1;
  end

  // Period counter and pause control; a pause toggle outranks a step, and rate only changes at a tick or on resume.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      period_cnt <= '0;
      TICK       <= 1'b0;
      PAUSED     <= 1'b0;
      RATE_Q     <= 2'b00;
    end else if (pause_press) begin
      PAUSED     <= ~PAUSED;
      period_cnt <= '0;
      TICK       <= 1'b0;
      if (PAUSED) begin
        RATE_Q <= sw_sync;
      end
    end else if (PAUSED) begin
      TICK <= step_press;
    end else if (period_cnt == period_last) begin
      TICK       <= 1'b1;
      period_cnt <= '0;
      RATE_Q     <= sw_sync;
    end else begin
      TICK       <= 1'b0;
      period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule
